dll_tx_dllp_scheduler: RTL and testbench

- Transmit-side DLLP scheduler for the DLL active state.
- Shares a single 48-bit DLLP transmit slot between three requesters: Ack, Nak and UpdateFC (P/NP/Cpl).
- Builds the DLLP with CRC-16 and presents it on a valid/ready handshake to the PHY framing path.
- Emitted UpdateFC DLLPs are decodable by the RX DLLP checker.

---
 rtl/dll_tx_dllp_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_dll_tx_dllp_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dll_tx_dllp_scheduler.sv
// Transmit DLLP scheduler: arbitrates Ack/Nak and UpdateFC requests onto one CRC-protected DLLP slot.
// Define DLLP_TX_FC_TIMER_EN to add the periodic UpdateFC timer (period UPDATEFC_PERIOD cycles).
module dll_tx_dllp_scheduler #(
   parameter int unsigned UPDATEFC_PERIOD = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        link_active_i,
   input  logic        ack_req_i,
   input  logic        nak_req_i,
   input  logic [11:0] ackseq_i,
   input  logic [2:0]  fc_req_i,
   input  logic [17:0] fc_hdr_i,
   input  logic [35:0] fc_data_i,
   output logic [47:0] dllp_o,
   output logic        dllp_valid_o,
   input  logic        dllp_ready_i,
   output logic        acknak_sent_o,
   output logic [2:0]  fc_sent_o
);

   typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

   state_t      state, state_next;
   logic        acknak_pend, nak_flag;
   logic [11:0] ackseq_q;
   logic [2:0]  fc_pend;
   logic [1:0]  rr_ptr;
   logic        sel_acknak;
   logic [2:0]  sel_fc;
   logic [47:0] dllp_q;
   logic        accept, fc_tick, select;
   logic        acknak_eff, nak_eff, any_pend;
   logic [11:0] seq_eff;
   logic [2:0]  fc_eff, grant_fc;
   logic [7:0]  fc_type;
   logic [5:0]  fc_hdr;
   logic [11:0] fc_data;
   logic [31:0] body_next;

   function automatic logic [15:0] crc16(input logic [31:0] d);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 31; i >= 0; i--) begin
         c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

`ifdef DLLP_TX_FC_TIMER_EN
   logic [15:0] timer;

   assign fc_tick = link_active_i && (timer == 16'(UPDATEFC_PERIOD - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         timer <= 16'h0;
      else if (!link_active_i || fc_tick)
         timer <= 16'h0;
      else
         timer <= timer + 16'h1;
   end
`else
   assign fc_tick = 1'b0;
`endif

   assign accept = (state == SEND) && dllp_ready_i;
   assign select = (state == IDLE) && link_active_i && any_pend;

   // Same-cycle requests join the pending set so a fresh request can be selected immediately.
   always_comb begin
      acknak_eff = acknak_pend | ack_req_i | nak_req_i;
      nak_eff    = nak_flag;
      if (nak_req_i)
         nak_eff = 1'b1;
      else if (ack_req_i)
         nak_eff = 1'b0;
      seq_eff  = (ack_req_i || nak_req_i) ? ackseq_i : ackseq_q;
      fc_eff   = fc_pend | fc_req_i | {3{fc_tick}};
      any_pend = acknak_eff | (|fc_eff);
   end

   always_comb begin
      grant_fc = 3'b000;
      case (rr_ptr)
         2'd1: begin
            if (fc_eff[1])      grant_fc = 3'b010;
            else if (fc_eff[2]) grant_fc = 3'b100;
            else if (fc_eff[0]) grant_fc = 3'b001;
         end
         2'd2: begin
            if (fc_eff[2])      grant_fc = 3'b100;
            else if (fc_eff[0]) grant_fc = 3'b001;
            else if (fc_eff[1]) grant_fc = 3'b010;
         end
         default: begin
            if (fc_eff[0])      grant_fc = 3'b001;
            else if (fc_eff[1]) grant_fc = 3'b010;
            else if (fc_eff[2]) grant_fc = 3'b100;
         end
      endcase
   end

   always_comb begin
      fc_type = 8'h80;
      fc_hdr  = fc_hdr_i[5:0];
      fc_data = fc_data_i[11:0];
      if (grant_fc[1]) begin
         fc_type = 8'h90;
         fc_hdr  = fc_hdr_i[11:6];
         fc_data = fc_data_i[23:12];
      end else if (grant_fc[2]) begin
         fc_type = 8'hA0;
         fc_hdr  = fc_hdr_i[17:12];
         fc_data = fc_data_i[35:24];
      end
      body_next = '0;
      if (acknak_eff) begin
         body_next[7:0]   = nak_eff ? 8'h10 : 8'h00;
         body_next[19:16] = seq_eff[11:8];
         body_next[31:24] = seq_eff[7:0];
      end else begin
         body_next[7:0]   = fc_type;
         body_next[13:8]  = fc_hdr;
         body_next[19:16] = fc_data[11:8];
         body_next[31:24] = fc_data[7:0];
      end
   end

   // A request arriving on the accept cycle of its own type keeps the bit set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acknak_pend <= 1'b0;
         nak_flag    <= 1'b0;
         ackseq_q    <= 12'h0;
         fc_pend     <= 3'b000;
         rr_ptr      <= 2'd0;
      end else if (!link_active_i) begin
         acknak_pend <= 1'b0;
         nak_flag    <= 1'b0;
         ackseq_q    <= 12'h0;
         fc_pend     <= 3'b000;
         rr_ptr      <= 2'd0;
      end else begin
         acknak_pend <= (acknak_pend & ~(accept & sel_acknak)) | ack_req_i | nak_req_i;
         if (nak_req_i)
            nak_flag <= 1'b1;
         else if (ack_req_i)
            nak_flag <= 1'b0;
         if (ack_req_i || nak_req_i)
            ackseq_q <= ackseq_i;
         fc_pend <= (fc_pend & ~({3{accept}} & sel_fc)) | fc_req_i | {3{fc_tick}};
         if (accept && !sel_acknak) begin
            if (sel_fc[0])      rr_ptr <= 2'd1;
            else if (sel_fc[1]) rr_ptr <= 2'd2;
            else                rr_ptr <= 2'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dllp_q     <= 48'h0;
         sel_acknak <= 1'b0;
         sel_fc     <= 3'b000;
      end else if (select) begin
         dllp_q     <= {16'h0000, body_next};
         sel_acknak <= acknak_eff;
         sel_fc     <= acknak_eff ? 3'b000 : grant_fc;
      end else if (state == CALC) begin
         dllp_q[47:32] <= crc16(dllp_q[31:0]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (!link_active_i) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:    if (any_pend) state_next = CALC;
            CALC:    state_next = SEND;
            SEND:    if (dllp_ready_i) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      dllp_valid_o  = (state == SEND);
      acknak_sent_o = accept & sel_acknak;
      fc_sent_o     = accept ? sel_fc : 3'b000;
      dllp_o        = dllp_q;
   end

endmodule

// File: tb/tb_dll_tx_dllp_scheduler.sv
// Self-checking bench for dll_tx_dllp_scheduler: frame-level reference model plus directed scenarios.
// Honours DLLP_TX_FC_TIMER_EN the same way as the design (period 16 here).
module tb_dll_tx_dllp_scheduler;

   localparam int PERIOD = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        link_active_i;
   logic        ack_req_i, nak_req_i;
   logic [11:0] ackseq_i;
   logic [2:0]  fc_req_i;
   logic [17:0] fc_hdr_i;
   logic [35:0] fc_data_i;
   logic [47:0] dllp_o;
   logic        dllp_valid_o;
   logic        dllp_ready_i;
   logic        acknak_sent_o;
   logic [2:0]  fc_sent_o;

   int errors = 0;
   int checks = 0;
   logic [47:0] frames[$];

   // Reference model state: phase 0 waiting, 1 building, 2 offered; kind 0..2 = P/NP/Cpl, 3 = Ack/Nak.
   int          m_phase, m_kind, m_rr, m_timer;
   logic        m_ack, m_nak, m_acc, m_tick;
   logic [11:0] m_seq;
   logic [2:0]  m_fc;
   logic [47:0] m_frame;

   dll_tx_dllp_scheduler #(.UPDATEFC_PERIOD(PERIOD)) dut (
      .clk(clk), .rst_n(rst_n), .link_active_i(link_active_i),
      .ack_req_i(ack_req_i), .nak_req_i(nak_req_i), .ackseq_i(ackseq_i),
      .fc_req_i(fc_req_i), .fc_hdr_i(fc_hdr_i), .fc_data_i(fc_data_i),
      .dllp_o(dllp_o), .dllp_valid_o(dllp_valid_o), .dllp_ready_i(dllp_ready_i),
      .acknak_sent_o(acknak_sent_o), .fc_sent_o(fc_sent_o)
   );

   always #5 clk = ~clk;

   // CRC as polynomial long division of the init-adjusted message times x^16.
   function automatic logic [15:0] golden_crc(input logic [71:0] msg, input int nbits);
      logic [87:0] v;
      v = {msg, 16'h0000};
      v[nbits + 15 -: 16] = v[nbits + 15 -: 16] ^ 16'hFFFF;
      for (int i = nbits + 15; i >= 16; i--) begin
         if (v[i]) v[i -: 17] = v[i -: 17] ^ 17'h11021;
      end
      return v[15:0];
   endfunction

   function automatic logic [47:0] model_frame(input int kind, input logic nak, input logic [11:0] seq,
                                               input logic [17:0] hdr, input logic [35:0] data);
      logic [7:0]  t;
      logic [5:0]  h;
      logic [11:0] v;
      logic [31:0] b;
      if (kind == 3) begin
         t = nak ? 8'h10 : 8'h00;
         h = 6'h00;
         v = seq;
      end else begin
         t = (kind == 0) ? 8'h80 : (kind == 1) ? 8'h90 : 8'hA0;
         h = hdr[6*kind +: 6];
         v = data[12*kind +: 12];
      end
      b = {v[7:0], 4'h0, v[11:8], 2'b00, h, t};
      return {golden_crc({40'h0, b}, 32), b};
   endfunction

   task automatic check_output(input string name, input logic [47:0] actual, input logic [47:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_kind = 0; m_rr = 0; m_timer = 0;
         m_ack = 0; m_nak = 0; m_seq = 0; m_fc = 0; m_frame = 0;
      end else if (!link_active_i) begin
         m_phase = 0; m_rr = 0; m_timer = 0;
         m_ack = 0; m_nak = 0; m_fc = 0;
      end else begin
         m_acc  = (m_phase == 2) && dllp_ready_i;
         m_tick = 1'b0;
`ifdef DLLP_TX_FC_TIMER_EN
         m_tick  = (m_timer == PERIOD - 1);
         m_timer = m_tick ? 0 : m_timer + 1;
`endif
         if (m_acc) begin
            if (m_kind == 3) m_ack = 0;
            else begin
               m_fc[m_kind] = 0;
               m_rr = (m_kind + 1) % 3;
            end
         end
         if (ack_req_i || nak_req_i) begin
            m_ack = 1;
            m_nak = nak_req_i;
            m_seq = ackseq_i;
         end
         m_fc = m_fc | fc_req_i | {3{m_tick}};
         if (m_phase == 0) begin
            if (m_ack || (m_fc != 0)) begin
               if (m_ack) m_kind = 3;
               else begin
                  m_kind = -1;
                  for (int k = 0; k < 3; k++)
                     if (m_kind < 0 && m_fc[(m_rr + k) % 3]) m_kind = (m_rr + k) % 3;
               end
               m_frame = model_frame(m_kind, m_nak, m_seq, fc_hdr_i, fc_data_i);
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else if (m_acc) begin
            m_phase = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check_output("valid", 48'(dllp_valid_o), 48'(m_phase == 2));
         if (m_phase == 2) check_output("dllp", dllp_o, m_frame);
         check_output("acknak_sent", 48'(acknak_sent_o),
                      48'(m_phase == 2 && dllp_ready_i && m_kind == 3));
         check_output("fc_sent", 48'(fc_sent_o),
                      (m_phase == 2 && dllp_ready_i && m_kind < 3) ? 48'(1 << m_kind) : 48'h0);
         if (dllp_valid_o && dllp_ready_i) frames.push_back(dllp_o);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      link_active_i = 1'b0;
      step();
      link_active_i = 1'b1;
   endtask

   task automatic wait_frames(input int n, input int limit);
      for (int i = 0; i < limit && frames.size() < n; i++) step();
      check_output("frame_count_reached", 48'(frames.size() >= n), 48'h1);
   endtask

   task automatic apply_stimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         link_active_i = ($urandom_range(0, 99) >= 3);
         ack_req_i     = ($urandom_range(0, 99) < 5);
         nak_req_i     = ($urandom_range(0, 99) < 3);
         ackseq_i      = 12'($urandom);
         for (int k = 0; k < 3; k++) fc_req_i[k] = ($urandom_range(0, 99) < 5);
         fc_hdr_i      = 18'($urandom);
         fc_data_i     = {4'($urandom), 32'($urandom)};
         dllp_ready_i  = ($urandom_range(0, 99) < 70);
         step();
      end
      ack_req_i = 0; nak_req_i = 0; fc_req_i = 0; link_active_i = 1; dllp_ready_i = 1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [71:0] check_str;
      rst_n = 0; link_active_i = 0; ack_req_i = 0; nak_req_i = 0; ackseq_i = 0;
      fc_req_i = 0; fc_hdr_i = 0; fc_data_i = 0; dllp_ready_i = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("reset_dllp", dllp_o, 48'h0);
      check_output("reset_valid", 48'(dllp_valid_o), 48'h0);
      check_output("reset_acknak_sent", 48'(acknak_sent_o), 48'h0);
      check_output("reset_fc_sent", 48'(fc_sent_o), 48'h0);
      check_str = "123456789";
      check_output("golden_crc_ref", 48'(golden_crc(check_str, 72)), 48'h29B1);

      @(posedge clk); #1;
      rst_n = 1; link_active_i = 1; dllp_ready_i = 1;
      step();

      // Ack seq A5C: valid two cycles after the request, for exactly one cycle.
      $display("[TB] Ack latency");
      flush();
      ack_req_i = 1; ackseq_i = 12'hA5C;
      step();
      ack_req_i = 0;
      step();
      @(negedge clk);
      check_output("ack_valid_n2", 48'(dllp_valid_o), 48'h1);
      check_output("ack_body", 48'(dllp_o[31:0]), 48'h5C0A_0000);
      check_output("ack_crc", 48'(dllp_o[47:32]), 48'(golden_crc({40'h0, 32'h5C0A_0000}, 32)));
      check_output("ack_sent_pulse", 48'(acknak_sent_o), 48'h1);
      step();
      @(negedge clk);
      check_output("ack_valid_drop", 48'(dllp_valid_o), 48'h0);

      // Three UpdateFC types in round-robin order.
      $display("[TB] UpdateFC burst");
      flush();
      frames.delete();
      fc_hdr_i  = {6'h04, 6'h08, 6'h10};
      fc_data_i = {12'h1FF, 12'h000, 12'h040};
      fc_req_i  = 3'b111;
      step();
      fc_req_i = 0;
      wait_frames(3, 20);
      check_output("fc0_body", 48'(frames[0][31:0]), 48'h4000_1080);
      check_output("fc1_body", 48'(frames[1][31:0]), 48'h0000_0890);
      check_output("fc2_body", 48'(frames[2][31:0]), 48'hFF01_04A0);
      check_output("fc0_crc", 48'(frames[0][47:32]), 48'(golden_crc({40'h0, 32'h4000_1080}, 32)));
      check_output("fc1_crc", 48'(frames[1][47:32]), 48'(golden_crc({40'h0, 32'h0000_0890}, 32)));
      check_output("fc2_crc", 48'(frames[2][47:32]), 48'(golden_crc({40'h0, 32'hFF01_04A0}, 32)));

      // Ack arrives while NP is stalled; it must go out ahead of Cpl.
      $display("[TB] Ack preempts pending Cpl");
      flush();
      frames.delete();
      fc_req_i = 3'b111;
      step();
      fc_req_i = 0;
      wait_frames(1, 10);
      dllp_ready_i = 0;
      for (int i = 0; i < 10 && !dllp_valid_o; i++) step();
      ack_req_i = 1; ackseq_i = 12'h123;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_output("stall_valid", 48'(dllp_valid_o), 48'h1);
         check_output("stall_body", 48'(dllp_o[31:0]), 48'h0000_0890);
         step();
         ack_req_i = 0;
      end
      dllp_ready_i = 1;
      wait_frames(4, 20);
      check_output("order_np", 48'(frames[1][7:0]), 48'h90);
      check_output("order_ack", 48'(frames[2][31:0]), 48'h2301_0000);
      check_output("order_cpl", 48'(frames[3][7:0]), 48'hA0);

      // Ack then Nak before selection collapse into a single Nak with the latest seq.
      $display("[TB] Ack/Nak coalesce");
      flush();
      frames.delete();
      dllp_ready_i = 0;
      fc_req_i = 3'b001;
      step();
      fc_req_i = 0; ack_req_i = 1; ackseq_i = 12'h001;
      step();
      ack_req_i = 0; nak_req_i = 1; ackseq_i = 12'h002;
      step();
      nak_req_i = 0; dllp_ready_i = 1;
      wait_frames(2, 20);
      check_output("coalesce_p", 48'(frames[0][7:0]), 48'h80);
      check_output("coalesce_nak", 48'(frames[1][31:0]), 48'h0200_0010);
      check_output("coalesce_nak_crc", 48'(frames[1][47:32]), 48'(golden_crc({40'h0, 32'h0200_0010}, 32)));

      // Flush during SEND drops valid and every pending request.
      $display("[TB] Flush");
      flush();
      dllp_ready_i = 0;
      fc_req_i = 3'b010;
      step();
      fc_req_i = 0;
      for (int i = 0; i < 10 && !dllp_valid_o; i++) step();
      ack_req_i = 1; fc_req_i = 3'b100;
      step();
      link_active_i = 0; fc_req_i = 0;
      step();
      link_active_i = 1; ack_req_i = 0; dllp_ready_i = 1;
      @(negedge clk);
      check_output("flush_valid", 48'(dllp_valid_o), 48'h0);
      frames.delete();
      repeat (10) step();
      check_output("flush_no_frames", 48'(frames.size()), 48'h0);

      // Periodic UpdateFC: nine DLLPs in 64 cycles when the timer is built in, none otherwise.
      $display("[TB] Timer");
      flush();
      frames.delete();
      repeat (64) step();
`ifdef DLLP_TX_FC_TIMER_EN
      check_output("timer_frames", 48'(frames.size()), 48'd9);
      check_output("timer_first_p", 48'(frames[0][7:0]), 48'h80);
      check_output("timer_third_cpl", 48'(frames[2][7:0]), 48'hA0);
`else
      check_output("timer_frames", 48'(frames.size()), 48'd0);
`endif

      $display("[TB] Random traffic");
      apply_stimulus(1500);
      repeat (10) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
